// File: rtl/ram_rd_ctrl_if.sv
// Signal bundle for ram_rd_ctrl: transfer control, RAM port-B read bus and
// the valid/ready output stream. The controller uses the master modport; the
// requester, RAM and downstream consumer together form the slave side.
interface ram_rd_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   rd_len;
  logic              busy;
  logic              done;
  logic              ram_enb;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_doutb;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  // Controller view.
  modport master (
    input  start, start_addr, rd_len, ram_doutb, m_ready,
    output busy, done, ram_enb, ram_addrb, m_data, m_valid
  );

  // Environment view: requester, RAM port B and stream consumer.
  modport slave (
    output start, start_addr, rd_len, ram_doutb, m_ready,
    input  busy, done, ram_enb, ram_addrb, m_data, m_valid
  );
endinterface

// File: rtl/ram_rd_ctrl.sv
// Read-side controller for the simple dual-port block RAM (port B).
// On start it sweeps a wrapping address range, tracks reads in flight through
// the RAM's fixed read latency, and buffers returned words in a small FIFO that
// feeds a valid/ready stream. Reads are only issued while buffer credit exists,
// so the FIFO can never overflow under any amount of backpressure.
module ram_rd_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  ram_rd_ctrl_if.master bus
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Wide enough for FIFO occupancy plus every read in flight.
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;          // next address to issue
  logic [LEN_W-1:0]  rem_q, rem_d;            // reads not yet issued
  logic              ram_enb_q, ram_enb_d;
  logic [ADDR_W-1:0] ram_addrb_q, ram_addrb_d;
  logic [RD_LAT-1:0] vld_q, vld_d;            // in-flight read tracker
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              m_valid;
  logic [CNT_W-1:0]  inflight_d;
  logic              credit_ok;

  assign push    = vld_q[RD_LAT-1];
  assign m_valid = (fifo_count_q != '0);
  assign pop     = m_valid && bus.m_ready;

  // Next-cycle occupancy of the latency tracker and FIFO, and the resulting credit.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    vld_d    = '0;
    vld_d[0] = ram_enb_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CNT_W'(1);
    end

    inflight_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_d = inflight_d + CNT_W'(vld_d[i]);
    end

    // A read issued next cycle must still find a free FIFO slot when it returns.
    credit_ok = (inflight_d + fifo_count_d) < CNT_W'(FIFO_DEPTH);
  end

  // Transfer FSM: next state, issue decision and address/length bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    ram_enb_d   = 1'b0;
    ram_addrb_d = ram_addrb_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.rd_len == '0) begin
            state_d = ST_DONE;
          end else begin
            // The FIFO is always empty in IDLE, so the first read needs no credit check.
            state_d     = ST_READ;
            ram_enb_d   = 1'b1;
            ram_addrb_d = bus.start_addr;
            addr_d      = bus.start_addr + ADDR_W'(1);
            rem_d       = bus.rd_len - LEN_W'(1);
          end
        end
      end
      ST_READ: begin
        if (rem_q == '0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          ram_enb_d   = 1'b1;
          ram_addrb_d = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        // Leave once nothing is in flight and this cycle's pop empties the FIFO.
        if (inflight_d == '0 && fifo_count_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and pointer registers; reset flushes the FIFO and drops in-flight reads.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      ram_enb_q    <= 1'b0;
      ram_addrb_q  <= '0;
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      ram_enb_q    <= ram_enb_d;
      ram_addrb_q  <= ram_addrb_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO storage: a word is written when its read exits the latency tracker.
  always_ff @(posedge sys_clk) begin
    // NOTE: storage is not reset; validity comes from the reset count and pointers.
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus.ram_doutb;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.ram_enb   = ram_enb_q;
  assign bus.ram_addrb = ram_addrb_q;
  assign bus.m_valid   = m_valid;
  // Forced to zero while empty so the stream data is clean out of reset.
  assign bus.m_data    = m_valid ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Self-checking bench for ram_rd_ctrl: a behavioural RAM on port B, a
// per-cycle transfer monitor, and a reference model that derives the expected
// word stream and address sweep directly from start address, length and RAM contents.
`timescale 1ns/1ps
module tb_ram_rd_ctrl;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int AWORDS     = 1 << ADDR_W;
  localparam int MAX_CYC    = 2000;

  logic sys_clk = 1'b0;
  logic sys_rst;

  ram_rd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_rd_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural RAM port B with RD_LAT cycles of read latency.
  logic [DATA_W-1:0] ram_mem [AWORDS];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge sys_clk) begin
    if (bus.ram_enb) rd_pipe[0] <= ram_mem[bus.ram_addrb];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_doutb = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected by run_transfer.
  int obs_words[$];
  int obs_addrs[$];
  int obs_enb_cnt, obs_done_cnt, obs_done_cyc, obs_first_valid, obs_last_hs;
  int obs_busy_err, obs_stall_err, obs_credit_err, obs_valid_cnt, obs_busy_fall;
  bit obs_timeout;

  task automatic preload(input int kind);
    for (int a = 0; a < AWORDS; a++) begin
      case (kind)
        0:       ram_mem[a] = DATA_W'(255 - a);
        1:       ram_mem[a] = DATA_W'(a);
        default: ram_mem[a] = DATA_W'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Pulses start in cycle 0 and monitors every cycle until busy falls after done.
  // mode: 0 = ready held high, 1 = ready 1,0,0,1 repeating, 2 = random ready.
  // restart_cyc > 0 injects a second start pulse with different arguments.
  task automatic run_transfer(input int addr, input int len, input int mode,
                              input int restart_cyc);
    int cyc, issued, popped;
    bit rdy, prev_stall;
    logic [DATA_W-1:0] prev_data;
    obs_words.delete();
    obs_addrs.delete();
    obs_enb_cnt = 0; obs_done_cnt = 0; obs_done_cyc = -1; obs_first_valid = -1;
    obs_last_hs = -1; obs_busy_err = 0; obs_stall_err = 0; obs_credit_err = 0;
    obs_valid_cnt = 0; obs_busy_fall = -1; obs_timeout = 1'b0;
    issued = 0; popped = 0; prev_stall = 1'b0; prev_data = '0;

    @(negedge sys_clk);
    bus.start      = 1'b1;
    bus.start_addr = ADDR_W'(addr);
    bus.rd_len     = (ADDR_W+1)'(len);
    bus.m_ready    = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc == restart_cyc) begin
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'(100);
        bus.rd_len     = (ADDR_W+1)'(3);
      end else begin
        bus.start = 1'b0;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.m_ready = rdy;

      if (bus.busy !== 1'b1) begin
        if (obs_done_cnt > 0) begin
          obs_busy_fall = cyc;
          break;
        end
        obs_busy_err++;
      end
      if (bus.ram_enb === 1'b1) begin
        obs_addrs.push_back(int'(bus.ram_addrb));
        obs_enb_cnt++;
        if (issued - popped >= FIFO_DEPTH) obs_credit_err++;
        issued++;
      end
      if (bus.m_valid === 1'b1) begin
        obs_valid_cnt++;
        if (obs_first_valid < 0) obs_first_valid = cyc;
        if (prev_stall && bus.m_data !== prev_data) obs_stall_err++;
        if (rdy) begin
          obs_words.push_back(int'(bus.m_data));
          obs_last_hs = cyc;
          popped++;
        end
      end
      prev_stall = (bus.m_valid === 1'b1) && !rdy;
      prev_data  = bus.m_data;
      if (bus.done === 1'b1) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
      end
      if (cyc >= MAX_CYC) begin
        obs_timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst        = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.rd_len     = '0;
    bus.m_ready    = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.ram_enb !== 1'b0) begin n_fail++; $display("FAIL reset_ram_enb: got %b expected 0", bus.ram_enb); end
    n_checks++; if (bus.ram_addrb !== '0) begin n_fail++; $display("FAIL reset_ram_addrb: got %0d expected 0", bus.ram_addrb); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    n_checks++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0d expected 0", bus.m_data); end
    sys_rst = 1'b0;
  endtask

  task automatic test_basic();
    preload(0);
    run_transfer(0, 16, 0, 0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout expected completion"); end
    n_checks++; if (obs_words.size() != 16) begin n_fail++; $display("FAIL basic_count: got %0d expected 16", obs_words.size()); end
    for (int k = 0; k < obs_words.size() && k < 16; k++) begin
      n_checks++;
      if (obs_words[k] != 255 - k) begin n_fail++; $display("FAIL basic_word[%0d]: got %0d expected %0d", k, obs_words[k], 255 - k); end
    end
    n_checks++; if (obs_first_valid != 2 + RD_LAT) begin n_fail++; $display("FAIL basic_first_valid: got %0d expected %0d", obs_first_valid, 2 + RD_LAT); end
    n_checks++; if (obs_last_hs != 16 + 1 + RD_LAT) begin n_fail++; $display("FAIL basic_last_hs: got %0d expected %0d", obs_last_hs, 17 + RD_LAT); end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d expected 1", obs_done_cnt); end
    n_checks++; if (obs_done_cyc != 16 + 2 + RD_LAT) begin n_fail++; $display("FAIL basic_done_cyc: got %0d expected %0d", obs_done_cyc, 18 + RD_LAT); end
    n_checks++; if (obs_busy_fall != 16 + 3 + RD_LAT) begin n_fail++; $display("FAIL basic_busy_fall: got %0d expected %0d", obs_busy_fall, 19 + RD_LAT); end
    n_checks++; if (obs_busy_err != 0) begin n_fail++; $display("FAIL basic_busy_low: got %0d cycles expected 0", obs_busy_err); end
    n_checks++; if (obs_enb_cnt != 16) begin n_fail++; $display("FAIL basic_enb_cnt: got %0d expected 16", obs_enb_cnt); end
    for (int k = 0; k < obs_addrs.size() && k < 16; k++) begin
      n_checks++;
      if (obs_addrs[k] != k) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", k, obs_addrs[k], k); end
    end
  endtask

  task automatic test_backpressure();
    preload(0);
    run_transfer(0, 16, 1, 0);
    n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL bp_timeout: got timeout expected completion"); end
    n_checks++; if (obs_words.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d expected 16", obs_words.size()); end
    for (int k = 0; k < obs_words.size() && k < 16; k++) begin
      n_checks++;
      if (obs_words[k] != 255 - k) begin n_fail++; $display("FAIL bp_word[%0d]: got %0d expected %0d", k, obs_words[k], 255 - k); end
    end
    n_checks++; if (obs_stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", obs_stall_err); end
    n_checks++; if (obs_credit_err != 0) begin n_fail++; $display("FAIL bp_credit: got %0d over-issues expected 0", obs_credit_err); end
    n_checks++; if (obs_enb_cnt != 16) begin n_fail++; $display("FAIL bp_enb_cnt: got %0d expected 16", obs_enb_cnt); end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d expected 1", obs_done_cnt); end
  endtask

  task automatic test_wrap();
    preload(1);
    run_transfer(250, 10, 0, 0);
    n_checks++; if (obs_addrs.size() != 10) begin n_fail++; $display("FAIL wrap_addr_cnt: got %0d expected 10", obs_addrs.size()); end
    for (int k = 0; k < obs_addrs.size() && k < 10; k++) begin
      n_checks++;
      if (obs_addrs[k] != (250 + k) % AWORDS) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, obs_addrs[k], (250 + k) % AWORDS); end
    end
    n_checks++; if (obs_words.size() != 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", obs_words.size()); end
    for (int k = 0; k < obs_words.size() && k < 10; k++) begin
      n_checks++;
      if (obs_words[k] != (250 + k) % AWORDS) begin n_fail++; $display("FAIL wrap_word[%0d]: got %0d expected %0d", k, obs_words[k], (250 + k) % AWORDS); end
    end
    n_checks++; if (obs_done_cyc != 10 + 2 + RD_LAT) begin n_fail++; $display("FAIL wrap_done_cyc: got %0d expected %0d", obs_done_cyc, 12 + RD_LAT); end
  endtask

  task automatic test_zero_len();
    run_transfer(17, 0, 0, 0);
    n_checks++; if (obs_done_cyc != 1) begin n_fail++; $display("FAIL zero_done_cyc: got %0d expected 1", obs_done_cyc); end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d expected 1", obs_done_cnt); end
    n_checks++; if (obs_busy_fall != 2) begin n_fail++; $display("FAIL zero_busy_fall: got %0d expected 2", obs_busy_fall); end
    n_checks++; if (obs_enb_cnt != 0) begin n_fail++; $display("FAIL zero_enb_cnt: got %0d expected 0", obs_enb_cnt); end
    n_checks++; if (obs_valid_cnt != 0) begin n_fail++; $display("FAIL zero_valid_cnt: got %0d expected 0", obs_valid_cnt); end
  endtask

  task automatic test_start_ignored();
    preload(0);
    run_transfer(0, 16, 0, 5);
    n_checks++; if (obs_words.size() != 16) begin n_fail++; $display("FAIL restart_count: got %0d expected 16", obs_words.size()); end
    for (int k = 0; k < obs_words.size() && k < 16; k++) begin
      n_checks++;
      if (obs_words[k] != 255 - k) begin n_fail++; $display("FAIL restart_word[%0d]: got %0d expected %0d", k, obs_words[k], 255 - k); end
    end
    n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d expected 1", obs_done_cnt); end
    n_checks++; if (obs_done_cyc != 16 + 2 + RD_LAT) begin n_fail++; $display("FAIL restart_done_cyc: got %0d expected %0d", obs_done_cyc, 18 + RD_LAT); end
    repeat (4) @(negedge sys_clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle_after: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int hs, cyc, stale;
    preload(0);
    hs = 0; cyc = 0; stale = 0;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.start_addr = '0; bus.rd_len = (ADDR_W+1)'(16); bus.m_ready = 1'b1;
    while (hs < 5 && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.m_valid === 1'b1) hs++;
    end
    n_checks++; if (hs != 5) begin n_fail++; $display("FAIL rstmid_pre_words: got %0d expected 5", hs); end
    @(negedge sys_clk);
    bus.m_ready = 1'b0;
    repeat (8) @(negedge sys_clk);
    n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_stalled_valid: got %b expected 1", bus.m_valid); end
    #2 sys_rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.ram_enb !== 1'b0) begin n_fail++; $display("FAIL rstmid_ram_enb: got %b expected 0", bus.ram_enb); end
    n_checks++; if (bus.ram_addrb !== '0) begin n_fail++; $display("FAIL rstmid_ram_addrb: got %0d expected 0", bus.ram_addrb); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid: got %b expected 0", bus.m_valid); end
    n_checks++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL rstmid_m_data: got %0d expected 0", bus.m_data); end
    @(negedge sys_clk);
    sys_rst     = 1'b0;
    bus.m_ready = 1'b1;
    repeat (10) begin
      @(negedge sys_clk);
      if (bus.m_valid !== 1'b0 || bus.ram_enb !== 1'b0 || bus.busy !== 1'b0) stale++;
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d active cycles expected 0", stale); end
    run_transfer(8, 4, 0, 0);
    n_checks++; if (obs_words.size() != 4) begin n_fail++; $display("FAIL rstmid_new_count: got %0d expected 4", obs_words.size()); end
    for (int k = 0; k < obs_words.size() && k < 4; k++) begin
      n_checks++;
      if (obs_words[k] != 247 - k) begin n_fail++; $display("FAIL rstmid_new_word[%0d]: got %0d expected %0d", k, obs_words[k], 247 - k); end
    end
    n_checks++; if (obs_done_cyc != 4 + 2 + RD_LAT) begin n_fail++; $display("FAIL rstmid_new_done_cyc: got %0d expected %0d", obs_done_cyc, 6 + RD_LAT); end
  endtask

  task automatic test_random();
    int addr, len, bad_words, bad_addrs;
    for (int it = 0; it < 20; it++) begin
      preload(2);
      addr = int'($urandom_range(0, AWORDS - 1));
      len  = (it % 7 == 6) ? 0 : int'($urandom_range(1, 40));
      run_transfer(addr, len, 2, 0);
      bad_words = 0;
      bad_addrs = 0;
      for (int k = 0; k < obs_words.size() && k < len; k++)
        if (obs_words[k] != int'(ram_mem[(addr + k) % AWORDS])) bad_words++;
      for (int k = 0; k < obs_addrs.size() && k < len; k++)
        if (obs_addrs[k] != (addr + k) % AWORDS) bad_addrs++;
      n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout expected completion", it); end
      n_checks++; if (obs_words.size() != len) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_words.size(), len); end
      n_checks++; if (bad_words != 0) begin n_fail++; $display("FAIL rand%0d_words: got %0d wrong words expected 0", it, bad_words); end
      n_checks++; if (obs_enb_cnt != len || bad_addrs != 0) begin n_fail++; $display("FAIL rand%0d_addrs: got %0d reads %0d wrong expected %0d reads 0 wrong", it, obs_enb_cnt, bad_addrs, len); end
      n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done_cnt: got %0d expected 1", it, obs_done_cnt); end
      n_checks++; if (obs_stall_err != 0 || obs_credit_err != 0) begin n_fail++; $display("FAIL rand%0d_flow: got stall=%0d credit=%0d expected 0 0", it, obs_stall_err, obs_credit_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
